// File: rtl/status_stack_unit_pkg.sv
// Shared definitions for the status/condition unit: flag positions,
// register operations, stack operations and condition test codes.
package status_pkg;

   localparam int F_Z   = 0;
   localparam int F_C   = 1;
   localparam int F_N   = 2;
   localparam int F_OVR = 3;

   typedef enum logic [2:0] {
      OP_LOAD       = 3'd0,
      OP_LOAD_CINV  = 3'd1,
      OP_LOAD_OVRET = 3'd2,
      OP_SET        = 3'd3,
      OP_RESET      = 3'd4,
      OP_LOAD_Y     = 3'd5,
      OP_SWAP       = 3'd6,
      OP_INVERT     = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      STK_NONE = 2'b00,
      STK_PUSH = 2'b01,
      STK_POP  = 2'b10,
      STK_XCHG = 2'b11
   } stk_op_e;

   // Condition codes; odd codes are the complement of the even code below them.
   localparam logic [3:0] CC_LE    = 4'h0;
   localparam logic [3:0] CC_GT    = 4'h1;
   localparam logic [3:0] CC_LT    = 4'h2;
   localparam logic [3:0] CC_GE    = 4'h3;
   localparam logic [3:0] CC_EQ    = 4'h4;
   localparam logic [3:0] CC_NE    = 4'h5;
   localparam logic [3:0] CC_OVR   = 4'h6;
   localparam logic [3:0] CC_NOVR  = 4'h7;
   localparam logic [3:0] CC_CORZ  = 4'h8;
   localparam logic [3:0] CC_NCNZ  = 4'h9;
   localparam logic [3:0] CC_C     = 4'hA;
   localparam logic [3:0] CC_NC    = 4'hB;
   localparam logic [3:0] CC_NCORZ = 4'hC;
   localparam logic [3:0] CC_CNZ   = 4'hD;
   localparam logic [3:0] CC_N     = 4'hE;
   localparam logic [3:0] CC_NN    = 4'hF;

endpackage

// File: rtl/status_stack_unit_lifo.sv
// MSR save/restore stack. Occupancy saturates at 0 and DEPTH; any push
// on a full stack or pop/exchange on an empty one sets a sticky error.
module status_lifo
   import status_pkg::*;
#(
   parameter int W_STAT = 4,
   parameter int DEPTH  = 8
)
(
   input  logic                       clk,
   input  logic                       nRST,
   input  logic [1:0]                 stkOp,
   input  logic [W_STAT-1:0]          msrOld,
   output logic [W_STAT-1:0]          stkTop,
   output logic                       restore,
   output logic [$clog2(DEPTH+1)-1:0] sp,
   output logic                       full,
   output logic                       empty,
   output logic                       err
);

   localparam int SPW = $clog2(DEPTH+1);
   localparam int IW  = $clog2(DEPTH);

   stk_op_e           opCode;
   logic [W_STAT-1:0] mem [DEPTH];
   logic [SPW-1:0]    spReg;
   logic [IW-1:0]     wrIdx;
   logic [IW-1:0]     topIdx;
   logic              errReg;
   logic              doPush;
   logic              doPop;
   logic              doXchg;
   logic              fault;

   assign opCode  = stk_op_e'(stkOp);
   assign full    = (spReg == SPW'(DEPTH));
   assign empty   = (spReg == '0);
   assign doPush  = (opCode == STK_PUSH) && !full;
   assign doPop   = (opCode == STK_POP)  && !empty;
   assign doXchg  = (opCode == STK_XCHG) && !empty;
   assign fault   = ((opCode == STK_PUSH) && full) ||
                    (((opCode == STK_POP) || (opCode == STK_XCHG)) && empty);
   assign wrIdx   = IW'(spReg);
   assign topIdx  = IW'(spReg - SPW'(1));
   // topIdx is meaningless when empty, but restore is low then
   assign stkTop  = mem[topIdx];
   assign restore = doPop | doXchg;
   assign sp      = spReg;
   assign err     = errReg;

   // Storage is deliberately left unreset; only the pointer defines validity.
   always_ff @(posedge clk) begin
      if (doPush)
         mem[wrIdx] <= msrOld;
      else if (doXchg)
         mem[topIdx] <= msrOld;
   end

   // Occupancy counter and sticky error flag.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         spReg  <= '0;
         errReg <= 1'b0;
      end else begin
         if (doPush)
            spReg <= spReg + SPW'(1);
         else if (doPop)
            spReg <= spReg - SPW'(1);
         if (fault)
            errReg <= 1'b1;
      end
   end

endmodule

// File: rtl/status_stack_unit.sv
// Micro/machine status registers, condition test and ALU carry-in select,
// with MSR save/restore through the status_lifo stack.
module status_stack_unit
   import status_pkg::*;
#(
   parameter int W_STAT = 4,
   parameter int DEPTH  = 8
)
(
   input  logic                       clk,
   input  logic                       nRST,
   input  logic [2:0]                 op,
   input  logic                       nCEu,
   input  logic                       nCEm,
   input  logic [W_STAT-1:0]          nEm,
   input  logic [W_STAT-1:0]          flags_in,
   input  logic [W_STAT-1:0]          yin,
   input  logic [1:0]                 stk_op,
   input  logic [4:0]                 cond,
   input  logic [1:0]                 cin_sel,
   input  logic                       cin_inv,
   input  logic                       Cx,
   output logic                       Co,
   output logic                       CT,
   output logic [W_STAT-1:0]          usr,
   output logic [W_STAT-1:0]          msr,
   output logic [$clog2(DEPTH+1)-1:0] sp,
   output logic                       full,
   output logic                       empty,
   output logic                       err
);

   op_e               opCode;
   logic [W_STAT-1:0] usrReg;
   logic [W_STAT-1:0] msrReg;
   logic [W_STAT-1:0] usrNext;
   logic [W_STAT-1:0] msrOpVal;
   logic [W_STAT-1:0] msrMask;
   logic [W_STAT-1:0] msrNext;
   logic [W_STAT-1:0] stkTop;
   logic [W_STAT-1:0] src;
   logic              stkRestore;
   logic              fz, fc, fn, fv, lt;
   logic              carrySel;

   assign opCode = op_e'(op);

   status_lifo #(.W_STAT(W_STAT), .DEPTH(DEPTH)) uLifo (
      .clk     (clk),
      .nRST    (nRST),
      .stkOp   (stk_op),
      .msrOld  (msrReg),
      .stkTop  (stkTop),
      .restore (stkRestore),
      .sp      (sp),
      .full    (full),
      .empty   (empty),
      .err     (err)
   );

   // Candidate next values for both registers as dictated by the op.
   always_comb begin
      usrNext  = usrReg;
      msrOpVal = msrReg;
      case (opCode)
         OP_LOAD: begin
            usrNext  = flags_in;
            msrOpVal = flags_in;
         end
         OP_LOAD_CINV: begin
            usrNext       = flags_in;
            usrNext[F_C]  = ~flags_in[F_C];
            msrOpVal      = flags_in;
            msrOpVal[F_C] = ~flags_in[F_C];
         end
         OP_LOAD_OVRET: begin
            usrNext         = flags_in;
            usrNext[F_OVR]  = flags_in[F_OVR] | usrReg[F_OVR];
            msrOpVal        = flags_in;
            msrOpVal[F_OVR] = flags_in[F_OVR] | msrReg[F_OVR];
         end
         OP_SET: begin
            usrNext  = '1;
            msrOpVal = '1;
         end
         OP_RESET: begin
            usrNext  = '0;
            msrOpVal = '0;
         end
         OP_LOAD_Y: begin
            usrNext  = msrReg;
            msrOpVal = yin;
         end
         OP_SWAP: begin
            usrNext  = msrReg;
            msrOpVal = usrReg;
         end
         OP_INVERT: begin
            msrOpVal = ~msrReg;
         end
         default: ;
      endcase
   end

   // A stack restore replaces the whole MSR and overrides the per-bit enables.
   assign msrMask = nCEm ? '0 : ~nEm;
   assign msrNext = stkRestore ? stkTop
                               : ((msrOpVal & msrMask) | (msrReg & ~msrMask));

   // Status register update.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         usrReg <= '0;
         msrReg <= '0;
      end else begin
         if (!nCEu)
            usrReg <= usrNext;
         msrReg <= msrNext;
      end
   end

   assign usr = usrReg;
   assign msr = msrReg;

   assign src = cond[4] ? msrReg : usrReg;
   assign fz  = src[F_Z];
   assign fc  = src[F_C];
   assign fn  = src[F_N];
   assign fv  = src[F_OVR];
   assign lt  = fn ^ fv;

   // Condition test on the selected register.
   always_comb begin
      CT = 1'b0;
      case (cond[3:0])
         CC_LE:    CT = lt | fz;
         CC_GT:    CT = ~lt & ~fz;
         CC_LT:    CT = lt;
         CC_GE:    CT = ~lt;
         CC_EQ:    CT = fz;
         CC_NE:    CT = ~fz;
         CC_OVR:   CT = fv;
         CC_NOVR:  CT = ~fv;
         CC_CORZ:  CT = fc | fz;
         CC_NCNZ:  CT = ~fc & ~fz;
         CC_C:     CT = fc;
         CC_NC:    CT = ~fc;
         CC_NCORZ: CT = ~fc | fz;
         CC_CNZ:   CT = fc & ~fz;
         CC_N:     CT = fn;
         CC_NN:    CT = ~fn;
         default:  CT = 1'b0;
      endcase
   end

   // ALU carry-in select with optional inversion.
   always_comb begin
      carrySel = 1'b0;
      case (cin_sel)
         2'b00:   carrySel = 1'b0;
         2'b01:   carrySel = 1'b1;
         2'b10:   carrySel = Cx;
         2'b11:   carrySel = fc;
         default: carrySel = 1'b0;
      endcase
      Co = carrySel ^ cin_inv;
   end

endmodule

// File: tb/tb_status_stack_unit.sv
module tb_status_stack_unit;
   import status_pkg::*;

   localparam int W = 4;
   localparam int D = 8;

   logic       clk = 1'b0;
   logic       nRST;
   logic [2:0] op;
   logic       nCEu, nCEm;
   logic [3:0] nEm, flags_in, yin;
   logic [1:0] stk_op;
   logic [4:0] cond;
   logic [1:0] cin_sel;
   logic       cin_inv, Cx;
   logic       Co, CT;
   logic [3:0] usr, msr;
   logic [3:0] sp;
   logic       full, empty, err;

   status_stack_unit #(.W_STAT(W), .DEPTH(D)) dut (
      .clk(clk), .nRST(nRST), .op(op), .nCEu(nCEu), .nCEm(nCEm), .nEm(nEm),
      .flags_in(flags_in), .yin(yin), .stk_op(stk_op), .cond(cond),
      .cin_sel(cin_sel), .cin_inv(cin_inv), .Cx(Cx), .Co(Co), .CT(CT),
      .usr(usr), .msr(msr), .sp(sp), .full(full), .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   int nCmp = 0;
   int nBad = 0;

   // reference model state: registers plus a queue as the stack
   logic [3:0] mUsr, mMsr;
   logic [3:0] mStk[$];
   logic       mErr;

   typedef struct {
      logic [2:0] op;
      logic       nCEu, nCEm;
      logic [3:0] nEm, flags, yin;
      logic [1:0] stk;
      logic [4:0] cond;
      logic [1:0] cs;
      logic       ci, cx;
      logic [3:0] eUsr, eMsr, eSp;
      logic       eCT, eCo;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // even codes test a base predicate, odd codes its complement
   function automatic logic ctRef(input logic [3:0] s, input logic [3:0] code);
      logic z, c, n, v, base;
      z = s[0]; c = s[1]; n = s[2]; v = s[3];
      base = 1'b0;
      case (code[3:1])
         3'd0: base = (n ^ v) | z;
         3'd1: base = n ^ v;
         3'd2: base = z;
         3'd3: base = v;
         3'd4: base = c | z;
         3'd5: base = c;
         3'd6: base = ~c | z;
         3'd7: base = n;
         default: base = 1'b0;
      endcase
      return base ^ code[0];
   endfunction

   function automatic logic coRef();
      logic [3:0] s;
      logic c;
      s = cond[4] ? mMsr : mUsr;
      c = 1'b0;
      case (cin_sel)
         2'd0: c = 1'b0;
         2'd1: c = 1'b1;
         2'd2: c = Cx;
         2'd3: c = s[1];
         default: c = 1'b0;
      endcase
      return c ^ cin_inv;
   endfunction

   task automatic modelStep();
      logic [3:0] uN, mN, mask, oldM, t;
      oldM = mMsr;
      uN = mUsr;
      mN = mMsr;
      case (op)
         3'd0: begin uN = flags_in; mN = flags_in; end
         3'd1: begin uN = flags_in ^ 4'b0010; mN = flags_in ^ 4'b0010; end
         3'd2: begin uN = flags_in | (mUsr & 4'b1000); mN = flags_in | (mMsr & 4'b1000); end
         3'd3: begin uN = 4'hF; mN = 4'hF; end
         3'd4: begin uN = 4'h0; mN = 4'h0; end
         3'd5: begin uN = mMsr; mN = yin; end
         3'd6: begin uN = mMsr; mN = mUsr; end
         default: begin uN = mUsr; mN = ~mMsr; end
      endcase
      mask = nCEm ? 4'h0 : ~nEm;
      mN = (mN & mask) | (mMsr & ~mask);
      case (stk_op)
         2'd1: if (mStk.size() == D) mErr = 1'b1; else mStk.push_back(oldM);
         2'd2: if (mStk.size() == 0) mErr = 1'b1; else mN = mStk.pop_back();
         2'd3: if (mStk.size() == 0) mErr = 1'b1;
               else begin
                  t = mStk[mStk.size()-1];
                  mStk[mStk.size()-1] = oldM;
                  mN = t;
               end
         default: ;
      endcase
      if (!nCEu) mUsr = uN;
      mMsr = mN;
   endtask

   task automatic checkAll(input string tag);
      chk({tag, ".usr"},   32'(usr),   32'(mUsr));
      chk({tag, ".msr"},   32'(msr),   32'(mMsr));
      chk({tag, ".sp"},    32'(sp),    32'(mStk.size()));
      chk({tag, ".full"},  32'(full),  32'(mStk.size() == D));
      chk({tag, ".empty"}, 32'(empty), 32'(mStk.size() == 0));
      chk({tag, ".err"},   32'(err),   32'(mErr));
      chk({tag, ".CT"},    32'(CT),    32'(ctRef(cond[4] ? mMsr : mUsr, cond[3:0])));
      chk({tag, ".Co"},    32'(Co),    32'(coRef()));
   endtask

   task automatic step(input string tag);
      modelStep();
      @(posedge clk);
      #1;
      checkAll(tag);
   endtask

   task automatic idle();
      op = 3'd0; nCEu = 1'b1; nCEm = 1'b1; nEm = 4'hF; stk_op = 2'd0;
   endtask

   task automatic resetNow();
      nRST = 1'b0;
      #1;
      chk("rst.sp", 32'(sp), 32'd0);
      chk("rst.msr", 32'(msr), 32'd0);
      chk("rst.usr", 32'(usr), 32'd0);
      chk("rst.err", 32'(err), 32'd0);
      mUsr = 4'h0; mMsr = 4'h0; mErr = 1'b0; mStk.delete();
      #2;
      nRST = 1'b1;
   endtask

   initial begin
      //          op   u  m  nEm   fl    yin  stk  cond   cs ci cx  eU    eM    eSp  CT Co
      tbl[0]  = '{3'd1, 0, 1, 4'hF, 4'h3, 4'h0, 2'd0, 5'h00, 3, 0, 0, 4'h1, 4'h0, 4'd0, 1, 0};
      tbl[1]  = '{3'd0, 1, 1, 4'hF, 4'h3, 4'h0, 2'd0, 5'h0A, 3, 1, 0, 4'h1, 4'h0, 4'd0, 0, 1};
      tbl[2]  = '{3'd0, 1, 0, 4'h0, 4'hA, 4'h0, 2'd0, 5'h10, 2, 0, 1, 4'h1, 4'hA, 4'd0, 1, 1};
      tbl[3]  = '{3'd0, 1, 1, 4'hF, 4'hA, 4'h0, 2'd1, 5'h1E, 1, 0, 0, 4'h1, 4'hA, 4'd1, 0, 1};
      tbl[4]  = '{3'd0, 1, 0, 4'h0, 4'h5, 4'h0, 2'd0, 5'h14, 0, 1, 0, 4'h1, 4'h5, 4'd1, 1, 1};
      tbl[5]  = '{3'd0, 1, 1, 4'hF, 4'h5, 4'h0, 2'd1, 5'h1B, 3, 0, 0, 4'h1, 4'h5, 4'd2, 1, 0};
      tbl[6]  = '{3'd3, 1, 0, 4'h0, 4'h5, 4'h0, 2'd0, 5'h17, 3, 0, 0, 4'h1, 4'hF, 4'd2, 0, 1};
      tbl[7]  = '{3'd0, 1, 1, 4'hF, 4'h5, 4'h0, 2'd2, 5'h1D, 3, 0, 0, 4'h1, 4'h5, 4'd1, 0, 0};
      tbl[8]  = '{3'd0, 1, 1, 4'hF, 4'h5, 4'h0, 2'd2, 5'h19, 3, 1, 0, 4'h1, 4'hA, 4'd0, 0, 0};
      tbl[9]  = '{3'd6, 0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 5'h0E, 3, 0, 0, 4'hA, 4'h1, 4'd0, 0, 1};
      tbl[10] = '{3'd5, 0, 0, 4'hC, 4'h0, 4'hF, 2'd0, 5'h18, 3, 0, 0, 4'h1, 4'h3, 4'd0, 1, 1};
      tbl[11] = '{3'd7, 0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 5'h16, 0, 0, 0, 4'h1, 4'hC, 4'd0, 1, 0};

      nRST = 1'b0;
      idle();
      flags_in = 4'h0; yin = 4'h0; cin_sel = 2'd0; cin_inv = 1'b0; Cx = 1'b0;
      cond = 5'h04;
      mUsr = 4'h0; mMsr = 4'h0; mErr = 1'b0; mStk.delete();
      #1;
      chk("reset.usr", 32'(usr), 32'd0);
      chk("reset.msr", 32'(msr), 32'd0);
      chk("reset.sp", 32'(sp), 32'd0);
      chk("reset.empty", 32'(empty), 32'd1);
      chk("reset.full", 32'(full), 32'd0);
      chk("reset.err", 32'(err), 32'd0);
      chk("reset.CT04", 32'(CT), 32'd0);
      cond = 5'h05;
      #1;
      chk("reset.CT05", 32'(CT), 32'd1);
      #8;
      nRST = 1'b1;

      // directed vectors
      for (int i = 0; i < 12; i++) begin
         op = tbl[i].op; nCEu = tbl[i].nCEu; nCEm = tbl[i].nCEm; nEm = tbl[i].nEm;
         flags_in = tbl[i].flags; yin = tbl[i].yin; stk_op = tbl[i].stk;
         cond = tbl[i].cond; cin_sel = tbl[i].cs; cin_inv = tbl[i].ci; Cx = tbl[i].cx;
         modelStep();
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.usr", i), 32'(usr), 32'(tbl[i].eUsr));
         chk($sformatf("vec%0d.msr", i), 32'(msr), 32'(tbl[i].eMsr));
         chk($sformatf("vec%0d.sp", i),  32'(sp),  32'(tbl[i].eSp));
         chk($sformatf("vec%0d.err", i), 32'(err), 32'd0);
         chk($sformatf("vec%0d.CT", i),  32'(CT),  32'(tbl[i].eCT));
         chk($sformatf("vec%0d.Co", i),  32'(Co),  32'(tbl[i].eCo));
      end

      // fill the stack, overflow, then drain and underflow
      for (int k = 1; k <= 8; k++) begin
         idle(); nCEm = 1'b0; nEm = 4'h0; flags_in = 4'(k); step("fillLd");
         idle(); stk_op = 2'd1; step("fillPush");
      end
      chk("fill.full", 32'(full), 32'd1);
      chk("fill.sp", 32'(sp), 32'd8);
      idle(); nCEm = 1'b0; nEm = 4'h0; flags_in = 4'hC; step("ovfLd");
      idle(); stk_op = 2'd1; step("ovfPush");
      chk("ovf.sp", 32'(sp), 32'd8);
      chk("ovf.err", 32'(err), 32'd1);
      idle(); stk_op = 2'd2; step("drain");
      chk("ovf.topKept", 32'(msr), 32'd8);
      for (int k = 7; k >= 1; k--) begin
         idle(); stk_op = 2'd2; step("drain");
         chk("drain.msr", 32'(msr), 32'(k));
      end
      idle(); stk_op = 2'd2; step("udf");
      chk("udf.sp", 32'(sp), 32'd0);
      chk("udf.msr", 32'(msr), 32'd1);
      chk("udf.err", 32'(err), 32'd1);

      // push with a same-cycle MSR clear, then exchange
      resetNow();
      idle(); nCEm = 1'b0; nEm = 4'h0; flags_in = 4'h6; step("sameLd");
      idle(); stk_op = 2'd1; op = 3'd4; nCEm = 1'b0; nEm = 4'h0; step("samePush");
      chk("same.msr", 32'(msr), 32'd0);
      chk("same.sp", 32'(sp), 32'd1);
      idle(); stk_op = 2'd3; step("xchg");
      chk("xchg.msr", 32'(msr), 32'd6);
      chk("xchg.sp", 32'(sp), 32'd1);
      idle(); stk_op = 2'd2; step("xchgPop");
      chk("xchg.top", 32'(msr), 32'd0);

      // async reset in mid-cycle with sp=3 and err set
      idle(); stk_op = 2'd2; step("preUdf");
      idle(); nCEm = 1'b0; nEm = 4'h0; flags_in = 4'h9; step("preLd");
      for (int k = 0; k < 3; k++) begin
         idle(); stk_op = 2'd1; step("prePush");
      end
      chk("pre.sp", 32'(sp), 32'd3);
      chk("pre.err", 32'(err), 32'd1);
      #2;
      resetNow();

      // randomized run against the model
      for (int i = 0; i < 450; i++) begin
         if (i % 150 == 149) begin
            @(posedge clk);
            #1;
            resetNow();
         end
         op = 3'($urandom_range(0, 7));
         nCEu = 1'($urandom_range(0, 1));
         nCEm = 1'($urandom_range(0, 1));
         nEm = 4'($urandom_range(0, 15));
         flags_in = 4'($urandom_range(0, 15));
         yin = 4'($urandom_range(0, 15));
         stk_op = 2'($urandom_range(0, 3));
         cond = 5'($urandom_range(0, 31));
         cin_sel = 2'($urandom_range(0, 3));
         cin_inv = 1'($urandom_range(0, 1));
         Cx = 1'($urandom_range(0, 1));
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/status_stack_unit.md
Name: status_stack_unit

Overview:
Parametrised successor to the microsequencer-side status/condition logic. Holds a micro status register (uSR) and a machine status register (MSR) of W_STAT flags, and evaluates a 5-bit condition code into CT. Drives the ALU carry-in mux. New in this generation: a DEPTH-entry LIFO stack that saves and restores MSR across microsubroutine and interrupt entry/exit, with full/empty flags and a sticky error flag.

Parameters:
W_STAT, 4, number of status flags; bit 0=Z, 1=C, 2=N, 3=OVR, bits 4..W_STAT-1 are user flags (W_STAT >= 4).
DEPTH, 8, status stack entries (>= 2).

Ports:
clk  in  1  clock, all state updates on rising edge
nRST  in  1  asynchronous active-low reset
op  in  3  register operation (see Behaviour)
nCEu  in  1  uSR update enable, active low
nCEm  in  1  MSR update enable, active low
nEm  in  W_STAT  per-bit MSR write enable, active low, ANDed with !nCEm
flags_in  in  W_STAT  ALU status (Z,C,N,OVR,user)
yin  in  W_STAT  status bus input
stk_op  in  2  00 none, 01 push, 10 pop, 11 exchange
cond  in  5  cond[4]: 0=uSR, 1=MSR; cond[3:0]: test code
cin_sel  in  2  00 -> 0, 01 -> 1, 10 -> Cx, 11 -> C of source cond[4]
cin_inv  in  1  invert selected carry
Cx  in  1  external carry
Co  out  1  carry-in to ALU
CT  out  1  condition test result
usr  out  W_STAT  uSR contents
msr  out  W_STAT  MSR contents
sp  out  $clog2(DEPTH+1)  stack occupancy
full  out  1  sp == DEPTH
empty  out  1  sp == 0
err  out  1  sticky stack overflow/underflow

Behaviour:
- Reset (async, nRST=0): uSR=0, MSR=0, sp=0, err=0, so full=0, empty=1. Stack storage is not reset; its contents are undefined.
- The op applies to uSR when !nCEu. It applies to MSR bit i when !nCEm && !nEm[i].
  - 0 LOAD: reg <= flags_in.
  - 1 LOAD_CINV: as LOAD with C inverted.
  - 2 LOAD_OVRET: as LOAD, but OVR <= flags_in.OVR | reg.OVR.
  - 3 SET: all ones.
  - 4 RESET: all zeros.
  - 5 LOAD_Y: MSR <= yin, uSR <= MSR (old value).
  - 6 SWAP: uSR <= MSR and MSR <= uSR, both old values.
  - 7 INVERT: MSR <= ~MSR; uSR is unchanged.
- All register updates take one cycle. Outputs usr/msr are registered values.
- push: stack[sp] <= MSR (pre-update value this cycle); sp <= sp+1. The same-cycle op still updates MSR.
- pop: MSR <= stack[sp-1], all bits, ignoring nEm. This has priority over op for MSR; uSR still follows op. sp <= sp-1.
- exchange: MSR <= stack[sp-1] and stack[sp-1] <= MSR (old). sp is unchanged. Priority over op for MSR.
- Push when full: no write, sp holds, err <= 1.
- Pop or exchange when empty: MSR follows op, sp holds, err <= 1.
- err is cleared only by reset.
- There is no wrap-around: sp saturates at 0 and DEPTH.
- CT is combinational from the selected source S (uSR or MSR) registered values, with cond[3:0]:
  - 0: (N^OVR)|Z
  - 1: ~(N^OVR)&~Z
  - 2: N^OVR
  - 3: ~(N^OVR)
  - 4: Z
  - 5: ~Z
  - 6: OVR
  - 7: ~OVR
  - 8: C|Z
  - 9: ~C&~Z
  - A: C
  - B: ~C
  - C: ~C|Z
  - D: C&~Z
  - E: N
  - F: ~N
- Co is combinational: selected carry XOR cin_inv. For cin_sel=11 the carry is C of source cond[4].

Decomposition:
- Package status_pkg holds:
  - the op enum (OP_LOAD..OP_INVERT);
  - the stk_op enum;
  - the cond code constants;
  - flag index constants F_Z=0, F_C=1, F_N=2, F_OVR=3.
- Sub-module status_lifo: DEPTH x W_STAT storage, sp counter, full/empty/err, and push/pop/exchange with an MSR write-back port.
- Register/condition logic stays in the top level.

Test Plan:
- Reset -> usr=0, msr=0, sp=0, empty=1, full=0, err=0. cond=5'h04 -> CT=0. cond=5'h05 -> CT=1.
- op=1, nCEu=0, flags_in=4'b0011 -> usr=4'b0001. Then cin_sel=11, cond[4]=0, cin_inv=0 -> Co=0; cin_inv=1 -> Co=1.
- W_STAT=4, DEPTH=8. Load MSR=4'hA and push. Load MSR=4'h5 and push. Set op=3 -> MSR=4'hF. Pop -> msr=5, sp=1. Pop -> msr=A, sp=0, empty=1.
- Push 8 times (full=1), then a 9th push -> sp=8, err=1, stack top unchanged. Pop 8 times, then one more pop -> sp=0, msr unchanged by stack, err stays 1.
- Same cycle: push with op=4, nCEm=0, MSR=4'h6 -> stack top=6, msr=0. Next cycle: exchange -> msr=6, top=0.
- Assert nRST mid-sequence with sp=3 -> next observed sp=0, msr=0, err=0 immediately, without waiting for a clock edge.
